// File: rtl/serial_add_ctrl_if.sv
// serial_add_ctrl_if: request/result bundle between a requester and the
// bit-serial add/subtract sequencer.
//   start, sub, a, b : request and operands, driven by the requester (master)
//   busy, done       : sequencer status; done is a one-cycle result-valid pulse
//   sum, cout, ovf   : registered result, held until the next accepted start
interface serial_add_ctrl_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output start, sub, a, b,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, sub, a, b,
    output busy, done, sum, cout, ovf
  );
endinterface

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial add/subtract sequencer built around a single
// 1-bit full-adder slice and a carry flip-flop. Operands are captured on an
// accepted start and processed LSB first, one bit per clock; the result is
// shifted into the sum register from the top.
//   clk  : rising-edge clock
//   rst  : synchronous reset, active-high, overrides everything
//   bus  : slave side of serial_add_ctrl_if (start/sub/a/b in,
//          busy/done/sum/cout/ovf out; all outputs registered)
module serial_add_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input logic              clk,
  input logic              rst,
  serial_add_ctrl_if.slave bus
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] areg_q, areg_d;
  logic [WIDTH-1:0] breg_q, breg_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // The shared 1-bit full-adder slice.
  logic slice_s;
  logic slice_c;
  assign slice_s = areg_q[0] ^ breg_q[0] ^ carry_q;
  assign slice_c = (areg_q[0] & breg_q[0]) | (areg_q[0] & carry_q) | (breg_q[0] & carry_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    areg_d  = areg_q;
    breg_d  = breg_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    case (state_q)
      StIdle: begin
        if (bus.start) begin
          // Subtraction as a + ~b + 1: invert B and preload carry-in with 1.
          areg_d  = bus.a;
          breg_d  = bus.sub ? ~bus.b : bus.b;
          carry_d = bus.sub;
          cnt_d   = '0;
          sum_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        sum_d   = {slice_s, sum_q[WIDTH-1:1]};
        areg_d  = areg_q >> 1;
        breg_d  = breg_q >> 1;
        carry_d = slice_c;
        cnt_d   = cnt_q + CntW'(1);
        if (cnt_q == CntLast) begin
          // MSB slice: carry out vs. carry in gives signed overflow.
          cout_d  = slice_c;
          ovf_d   = slice_c ^ carry_q;
          cnt_d   = '0;
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Status flags are registered from the next state so they line up with it.
    busy_d = (state_d != StIdle);
    done_d = (state_d == StDone);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      areg_q  <= '0;
      breg_q  <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      areg_q  <= areg_d;
      breg_q  <= breg_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed and random bench for serial_add_ctrl at WIDTH=8. Inputs are driven
// and outputs sampled on the falling edge.
module tb_serial_add_ctrl;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  serial_add_ctrl_if #(.WIDTH(8)) bus ();

  serial_add_ctrl #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: integer arithmetic, independent of the serial datapath.
  function automatic logic [9:0] model(input logic [7:0] ma, input logic [7:0] mb,
                                       input logic msub);
    int sa;
    int sb;
    int sr;
    int ur;
    logic [7:0] r;
    logic c;
    logic v;
    sa = int'($signed(ma));
    sb = int'($signed(mb));
    sr = msub ? (sa - sb) : (sa + sb);
    ur = msub ? (int'(ma) - int'(mb)) : (int'(ma) + int'(mb));
    r  = 8'(ur);
    c  = msub ? (ma >= mb) : (ur > 255);
    v  = (sr < -128) || (sr > 127);
    return {r, c, v};
  endfunction

  // Issues one op from IDLE; scrambles operands right after the start edge.
  task automatic run_op(input logic [7:0] ia, input logic [7:0] ib, input logic isub,
                        output logic [7:0] osum, output logic ocout, output logic oovf,
                        output int lat, output int busy_cnt, output logic pulse_ok);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = ia;
    bus.b     = ib;
    bus.sub   = isub;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = 8'($urandom);
    bus.b     = 8'($urandom);
    bus.sub   = 1'($urandom);
    lat       = 1;
    busy_cnt  = bus.busy ? 1 : 0;
    while (!bus.done && lat < 50) begin
      @(negedge clk);
      lat++;
      if (bus.busy) busy_cnt++;
    end
    osum  = bus.sum;
    ocout = bus.cout;
    oovf  = bus.ovf;
    @(negedge clk);
    pulse_ok = !bus.done && !bus.busy;
  endtask

  task automatic test_reset;
    logic [7:0] s;
    logic c, v, p;
    int lat, bc, ndone;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.sub   = 1'b0;
    bus.a     = 8'h00;
    bus.b     = 8'h00;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.busy, bus.done, bus.sum, bus.cout, bus.ovf} !== 12'h000) begin
      failures++;
      $display("FAIL reset_init: got busy=%b done=%b sum=%h cout=%b ovf=%b want all 0",
               bus.busy, bus.done, bus.sum, bus.cout, bus.ovf);
    end
    rst = 1'b0;
    // Leave cout/ovf set so clearing them by reset is observable.
    run_op(8'h80, 8'h80, 1'b0, s, c, v, lat, bc, p);
    checks++;
    if ({s, c, v} !== {8'h00, 1'b1, 1'b1}) begin
      failures++;
      $display("FAIL add_80_80: got sum=%h cout=%b ovf=%b want sum=00 cout=1 ovf=1", s, c, v);
    end
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 8'h55;
    bus.b     = 8'h55;
    bus.sub   = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({bus.busy, bus.done, bus.sum, bus.cout, bus.ovf} !== 12'h000) begin
      failures++;
      $display("FAIL reset_midrun: got busy=%b done=%b sum=%h cout=%b ovf=%b want all 0",
               bus.busy, bus.done, bus.sum, bus.cout, bus.ovf);
    end
    ndone = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.done || bus.busy) ndone++;
    end
    checks++;
    if (ndone !== 0) begin
      failures++;
      $display("FAIL reset_no_done: got %0d busy/done cycles after abort want 0", ndone);
    end
  endtask

  task automatic test_add;
    logic [7:0] s;
    logic c, v, p;
    int lat, bc;
    run_op(8'h35, 8'h2A, 1'b0, s, c, v, lat, bc, p);
    checks++;
    if ({s, c, v} !== {8'h5F, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL add_35_2a: got sum=%h cout=%b ovf=%b want sum=5f cout=0 ovf=0", s, c, v);
    end
    checks++;
    if (lat !== 9) begin
      failures++;
      $display("FAIL add_latency: got %0d clocks want 9", lat);
    end
    checks++;
    if (bc !== 9) begin
      failures++;
      $display("FAIL add_busy_cycles: got %0d want 9", bc);
    end
    checks++;
    if (p !== 1'b1) begin
      failures++;
      $display("FAIL add_done_pulse: got pulse_ok=%b want 1", p);
    end
    checks++;
    if (bus.sum !== 8'h5F) begin
      failures++;
      $display("FAIL add_sum_hold: got sum=%h want 5f", bus.sum);
    end
  endtask

  task automatic test_add_boundary;
    logic [7:0] s;
    logic c, v, p;
    int lat, bc;
    run_op(8'hFF, 8'h01, 1'b0, s, c, v, lat, bc, p);
    checks++;
    if ({s, c, v} !== {8'h00, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL add_ff_01: got sum=%h cout=%b ovf=%b want sum=00 cout=1 ovf=0", s, c, v);
    end
    run_op(8'h7F, 8'h01, 1'b0, s, c, v, lat, bc, p);
    checks++;
    if ({s, c, v} !== {8'h80, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL add_7f_01: got sum=%h cout=%b ovf=%b want sum=80 cout=0 ovf=1", s, c, v);
    end
  endtask

  task automatic test_sub;
    logic [7:0] s;
    logic c, v, p;
    int lat, bc;
    run_op(8'h10, 8'h20, 1'b1, s, c, v, lat, bc, p);
    checks++;
    if ({s, c, v} !== {8'hF0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL sub_10_20: got sum=%h cout=%b ovf=%b want sum=f0 cout=0 ovf=0", s, c, v);
    end
    run_op(8'h80, 8'h01, 1'b1, s, c, v, lat, bc, p);
    checks++;
    if ({s, c, v} !== {8'h7F, 1'b1, 1'b1}) begin
      failures++;
      $display("FAIL sub_80_01: got sum=%h cout=%b ovf=%b want sum=7f cout=1 ovf=1", s, c, v);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] va[0:39];
    logic [7:0] vb[0:39];
    logic       vs[0:39];
    logic [9:0] exp;
    int last_done;
    int ndone;
    last_done = -1;
    ndone     = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done) begin
        ndone++;
        if (last_done >= 0) begin
          checks++;
          if (i - last_done != 10) begin
            failures++;
            $display("FAIL b2b_spacing: got %0d clocks between done want 10", i - last_done);
          end
        end
        last_done = i;
        checks++;
        if (i < 9) begin
          failures++;
          $display("FAIL b2b_early_done: got done at cycle %0d want >= 9", i);
        end else begin
          exp = model(va[i-9], vb[i-9], vs[i-9]);
          if ({bus.sum, bus.cout, bus.ovf} !== exp) begin
            failures++;
            $display("FAIL b2b_result: got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
                     bus.sum, bus.cout, bus.ovf, exp[9:2], exp[1], exp[0]);
          end
        end
      end
      va[i]     = 8'(i * 37 + 5);
      vb[i]     = 8'(i * 11 + 3);
      vs[i]     = ((i % 2) == 1);
      bus.start = 1'b1;
      bus.a     = va[i];
      bus.b     = vb[i];
      bus.sub   = vs[i];
    end
    @(negedge clk);
    bus.start = 1'b0;
    checks++;
    if (ndone !== 4) begin
      failures++;
      $display("FAIL b2b_count: got %0d ops want 4", ndone);
    end
    repeat (12) @(negedge clk);
  endtask

  task automatic test_random;
    logic [7:0] ra, rb, s;
    logic rs, c, v, p;
    logic [9:0] exp;
    int lat, bc;
    for (int n = 0; n < 1000; n++) begin
      ra  = 8'($urandom);
      rb  = 8'($urandom);
      rs  = 1'($urandom);
      exp = model(ra, rb, rs);
      run_op(ra, rb, rs, s, c, v, lat, bc, p);
      checks++;
      if ({s, c, v} !== exp) begin
        failures++;
        $display("FAIL rand_result: a=%h b=%h sub=%b got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
                 ra, rb, rs, s, c, v, exp[9:2], exp[1], exp[0]);
      end
      checks++;
      if (lat !== 9 || p !== 1'b1) begin
        failures++;
        $display("FAIL rand_timing: got latency=%0d pulse_ok=%b want latency=9 pulse_ok=1",
                 lat, p);
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_add();
    test_add_boundary();
    test_sub();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
